// File: rtl/div_seq_unit_pkg.sv
// Shared definitions for the EX-stage divide sequencer.
//   DEF_DATA_W  : default datapath width (MIPS GPR width)
//   div_state_t : sequencer state encoding (IDLE, RUN, DBZ, DONE)
package cpu_defs;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DBZ  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_seq_unit_step.sv
// One combinational restoring-division iteration.
// Ports:
//   partial_rem  : running remainder (always < divisor on entry)
//   dividend_msb : next dividend bit shifted into the remainder
//   divisor      : magnitude of the divisor
//   next_rem     : remainder after the trial subtract (restored on failure)
//   q_bit        : quotient bit produced by this step
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] partial_rem,
    input  logic              dividend_msb,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] next_rem,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // partial_rem < divisor, so shifted < 2*divisor: one extra bit is enough
    // for the trial subtract and its sign bit is the borrow.
    always_comb begin
        shifted  = {partial_rem, dividend_msb};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[DATA_W];
        next_rem = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : divide request, held by EX until the pipeline advances
//   signed_div  : 1 = DIV, 0 = DIVU
//   opdata1/2   : dividend (rs) / divisor (rt)
//   annul       : flush cancel, beats start
//   stall       : combinational pipeline stall request
//   ready       : result valid (high for the whole DONE state)
//   result      : {remainder (HI), quotient (LO)}
module div_seq_unit
    import cpu_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    input  logic                annul,
    output logic                stall,
    output logic                ready,
    output logic [2*DATA_W-1:0] result
);

    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo_shift;   // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0] divisor_r;
    logic              signed_r, sign_q, sign_r;

    logic [DATA_W-1:0] step_rem, quo_next, q_fix, r_fix, abs1, abs2;
    logic              step_q, last_step, div_zero;

    div_step #(.DATA_W(DATA_W)) u_step (
        .partial_rem  (rem),
        .dividend_msb (quo_shift[DATA_W-1]),
        .divisor      (divisor_r),
        .next_rem     (step_rem),
        .q_bit        (step_q)
    );

    always_comb begin
        div_zero  = (opdata2 == '0);
        abs1      = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
        abs2      = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
        last_step = (count == CNT_W'(DATA_W-1));
        quo_next  = {quo_shift[DATA_W-2:0], step_q};
        q_fix     = (signed_r && sign_q) ? -quo_next : quo_next;
        r_fix     = (signed_r && sign_r) ? -step_rem : step_rem;
        stall     = start && !annul && (state != DONE);
        ready     = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (annul) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = div_zero ? DBZ : RUN;
                RUN:     if (last_step) state_nxt = DONE;
                DBZ:     state_nxt = DONE;
                DONE:    if (!start) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            rem       <= '0;
            quo_shift <= '0;
            divisor_r <= '0;
            signed_r  <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            result    <= '0;
        end else if (!annul) begin
            case (state)
                IDLE: if (start) begin
                    count     <= '0;
                    rem       <= '0;
                    // DBZ returns the raw dividend as remainder, so keep it
                    // unmodified when no division will run.
                    quo_shift <= div_zero ? opdata1 : abs1;
                    divisor_r <= abs2;
                    signed_r  <= signed_div;
                    sign_q    <= opdata1[DATA_W-1] ^ opdata2[DATA_W-1];
                    sign_r    <= opdata1[DATA_W-1];
                end
                RUN: begin
                    rem       <= step_rem;
                    quo_shift <= quo_next;
                    count     <= count + CNT_W'(1);
                    if (last_step) result <= {r_fix, q_fix};
                end
                DBZ:     result <= {quo_shift, {DATA_W{1'b1}}};
                default: ;
            endcase
        end
    end

endmodule
